ram_dump_reader: RTL and testbench

// - Read-side counterpart of the program-load path: the loader writes program/data bytes into the 16x8 RAM; this block reads them back.
// - On a start request, typically the CPU's HLT, it sweeps a RAM address window and streams each {address, byte} pair out over a valid/ready port.
// - Sits beside the RAM on its debug read port; used for post-run memory inspection and self-checking benches.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/ram_dump_reader.sv | 94 +++++++++
 tb/tb_ram_dump_reader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RAM geometry and the memory-dump FSM state type.
package cpu_pkg;

  localparam int unsigned RAM_ADDR_W = 4;
  localparam int unsigned RAM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    PRESENT,
    DONE
  } dump_state_t;

endpackage

// File: rtl/ram_dump_reader.sv
// Sweeps a RAM address window after a start request and streams each
// {address, byte} pair out over a valid/ready port, then pulses done.
module ram_dump_reader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = RAM_ADDR_W,
  parameter int unsigned DATA_W     = RAM_DATA_W,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] START_PTR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_PTR   = ADDR_W'(END_ADDR);

  dump_state_t       state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic              handshake;
  logic              last;

  assign handshake = (state == PRESENT) && dump_valid && dump_ready;
  // End compare precedes the increment, so a full-range window never wraps.
  assign last      = (ptr == END_PTR);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    state_next = CAPT;
      CAPT:    state_next = PRESENT;
      PRESENT: if (handshake) state_next = last ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from state_next so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      rd_en <= (state_next == READ);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            ptr     <= START_PTR;
            rd_addr <= START_PTR;
            busy    <= 1'b1;
          end
        end
        CAPT: begin
          dump_data  <= rd_data;
          dump_addr  <= ptr;
          dump_valid <= 1'b1;
        end
        PRESENT: begin
          if (handshake) begin
            dump_valid <= 1'b0;
            if (last) begin
              busy <= 1'b0;
            end else begin
              ptr     <= ptr + 1'b1;
              rd_addr <= ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dump_reader.sv
// Scoreboard bench for ram_dump_reader: full-range and narrow-window instances
// against behavioural RAM models and an expected-pair queue.
module tb_ram_dump_reader;
  import cpu_pkg::*;

  localparam int unsigned AW = RAM_ADDR_W;
  localparam int unsigned DW = RAM_DATA_W;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start, rd_en, dump_valid, dump_ready, busy, done;
  logic [AW-1:0] rd_addr, dump_addr;
  logic [DW-1:0] rd_data, dump_data;

  logic          start_w, rd_en_w, dump_valid_w, dump_ready_w, busy_w, done_w;
  logic [AW-1:0] rd_addr_w, dump_addr_w;
  logic [DW-1:0] rd_data_w, dump_data_w;

  logic [DW-1:0] mem   [16];
  logic [DW-1:0] mem_w [16];

  pair_t exp_q[$];
  pair_t exp_w[$];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int done_cnt_w = 0;
  int n_w = 0;

  int mode = 0;       // 0: ready always, 1: random ready, 2: stall on hold_addr
  int hold_addr = 0;
  int hold_len = 0;
  int hold_cnt = 0;
  logic [DW-1:0] held_data;

  ram_dump_reader #(
    .ADDR_W(AW), .DATA_W(DW), .START_ADDR(0), .END_ADDR(15)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .busy(busy), .done(done)
  );

  ram_dump_reader #(
    .ADDR_W(AW), .DATA_W(DW), .START_ADDR(9), .END_ADDR(10)
  ) dut_w (
    .clk(clk), .reset(reset), .start(start_w),
    .rd_en(rd_en_w), .rd_addr(rd_addr_w), .rd_data(rd_data_w),
    .dump_valid(dump_valid_w), .dump_ready(dump_ready_w),
    .dump_addr(dump_addr_w), .dump_data(dump_data_w),
    .busy(busy_w), .done(done_w)
  );

  // Synchronous-read RAMs: data appears the cycle after the strobe.
  always @(posedge clk) if (rd_en)   rd_data   <= mem[rd_addr];
  always @(posedge clk) if (rd_en_w) rd_data_w <= mem_w[rd_addr_w];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready driver for the full-range instance.
  always @(negedge clk) begin
    case (mode)
      0: dump_ready = 1'b1;
      1: dump_ready = 1'($urandom_range(0, 1));
      default: begin
        if (dump_valid && dump_addr == AW'(hold_addr) && hold_cnt < hold_len) begin
          if (hold_cnt == 0) held_data = dump_data;
          else begin
            check("hold_data_stable", dump_data, held_data);
            check("hold_data_ref", dump_data, mem[hold_addr]);
            check("hold_no_rd_en", rd_en, 0);
          end
          hold_cnt++;
          dump_ready = 1'b0;
        end else begin
          dump_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitors: a pair is consumed whenever valid && ready will meet the next edge.
  always @(negedge clk) begin
    pair_t p;
    #1;
    if (reset && dump_valid && dump_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        check("dump_addr", dump_addr, p.a);
        check("dump_data", dump_data, p.d);
      end
    end
    if (done) done_cnt++;
  end

  always @(negedge clk) begin
    pair_t p;
    #1;
    if (reset && dump_valid_w && dump_ready_w) begin
      n_w++;
      check("win_sb_nonempty", 32'(exp_w.size() != 0), 1);
      if (exp_w.size() != 0) begin
        p = exp_w.pop_front();
        check("win_dump_addr", dump_addr_w, p.a);
        check("win_dump_data", dump_data_w, p.d);
      end
    end
    if (reset && rd_en_w) check("win_rd_addr_range", 32'(rd_addr_w >= 9 && rd_addr_w <= 10), 1);
    if (done_w) done_cnt_w++;
  end

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_dump_valid"}, dump_valid, 0);
    check({tag, "_dump_addr"}, dump_addr, 0);
    check({tag, "_dump_data"}, dump_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic push_expected();
    for (int a = 0; a < 16; a++) begin
      pair_t p;
      p.a = AW'(a);
      p.d = mem[a];
      exp_q.push_back(p);
    end
  endtask

  task automatic run_dump(input string tag, input int budget, output int cyc);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_run"}, busy, 1);
    while (!done && cyc < budget) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    #2;
    check({tag, "_done_single"}, done, 0);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    int dc;
    reset = 1'b1;
    start = 1'b0;
    start_w = 1'b0;
    dump_ready_w = 1'b1;
    dump_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      mem_w[i] = DW'($urandom);
    end
    mem[9] = 8'h0B;
    mem[0] = 8'h79;
    mem_w[9] = 8'h0B;
    mem_w[10] = 8'h0B;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    check("reset_w_valid", dump_valid_w, 0);
    check("reset_w_busy", busy_w, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed full dump with ready tied high.
    mode = 0;
    dc = done_cnt;
    run_dump("basic", 200, cyc);
    check("basic_done_cycle", cyc, 49);
    check("basic_done_count", done_cnt - dc, 1);

    // Stall on address 3 for five cycles.
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    mode = 2; hold_addr = 3; hold_len = 5; hold_cnt = 0;
    run_dump("stall", 300, cyc);
    check("stall_hold_cycles", hold_cnt, 5);
    check("stall_done_cycle", cyc, 54);

    // Start re-asserted mid-dump is ignored.
    mode = 0;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    dc = done_cnt;
    fork
      run_dump("restart", 300, cyc);
      begin
        int w = 0;
        while (!(dump_valid && dump_addr == 4'd5) && w < 100) begin
          @(negedge clk);
          w++;
        end
        check("restart_reached_5", 32'(w < 100), 1);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("restart_done_count", done_cnt - dc, 1);
    check("restart_done_cycle", cyc, 49);

    // Reset while presenting address 7.
    mode = 2; hold_addr = 7; hold_len = 1000; hold_cnt = 0;
    dc = done_cnt;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(dump_valid && dump_addr == 4'd7) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_7", 32'(cyc < 200), 1);
    reset = 1'b0;
    #1;
    check_zero("abort");
    check("abort_remaining", exp_q.size(), 9);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - dc, 0);
    check("abort_idle_valid", dump_valid, 0);
    check("abort_idle_busy", busy, 0);

    // Randomised back-pressure, full sweep from START_ADDR again.
    mode = 1;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    dc = done_cnt;
    run_dump("random", 2000, cyc);
    check("random_done_count", done_cnt - dc, 1);
    check("random_min_cycles", 32'(cyc >= 49), 1);
    mode = 0;

    // Narrow window 9..10.
    for (int a = 9; a <= 10; a++) begin
      pair_t p;
      p.a = AW'(a);
      p.d = mem_w[a];
      exp_w.push_back(p);
    end
    @(negedge clk);
    start_w = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start_w = 1'b0;
    while (!done_w && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("win_done_cycle", cyc, 7);
    repeat (6) @(negedge clk);
    #2;
    check("win_pairs", n_w, 2);
    check("win_done_count", done_cnt_w, 1);
    check("win_sb_drained", exp_w.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
